// File: rtl/cpu_fetch_decode_exec.sv
// Fetch, decode and execute stage of the single-cycle MIPS-subset CPU.
// The PC register is the only state; everything else is combinational from inst/rd1/rd2/pc.
module cpu_fetch_decode_exec #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [4:0]  ra1,
  output logic [4:0]  ra2,
  output logic [4:0]  wa,
  output logic        reg_wen,
  output logic [1:0]  reg_src,
  output logic [1:0]  mem_cmd,
  output logic [1:0]  spi_ctrl,
  output logic [31:0] alu_out,
  output logic        carry_out,
  output logic        is_zero,
  output logic        is_syscall
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  logic [31:0] pc_q, pc_d;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] immS, immZ, brOffset;
  logic [31:0] aluA, aluB;
  logic [3:0]  aluOp;
  logic        isBeq, isBne, isJ, isJr;
  logic [32:0] sum;

  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];
  assign shamt = inst[10:6];
  assign funct = inst[5:0];
  assign immS  = {{16{inst[15]}}, inst[15:0]};
  assign immZ  = {16'h0000, inst[15:0]};
  assign brOffset = {immS[29:0], 2'b00};

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    ra1        = rs;
    ra2        = rt;
    wa         = rd;
    reg_wen    = 1'b0;
    reg_src    = 2'b00;
    mem_cmd    = 2'b00;
    spi_ctrl   = 2'b00;
    is_syscall = 1'b0;
    aluA       = rd1;
    aluB       = rd2;
    aluOp      = ALU_ADD;
    isBeq      = 1'b0;
    isBne      = 1'b0;
    isJ        = 1'b0;
    isJr       = 1'b0;
    case (op)
      6'h00: begin
        case (funct)
          6'h20, 6'h21: begin aluOp = ALU_ADD;  reg_wen = 1'b1; end
          6'h22, 6'h23: begin aluOp = ALU_SUB;  reg_wen = 1'b1; end
          6'h24: begin aluOp = ALU_AND;  reg_wen = 1'b1; end
          6'h25: begin aluOp = ALU_OR;   reg_wen = 1'b1; end
          6'h26: begin aluOp = ALU_XOR;  reg_wen = 1'b1; end
          6'h27: begin aluOp = ALU_NOR;  reg_wen = 1'b1; end
          6'h2A: begin aluOp = ALU_SLT;  reg_wen = 1'b1; end
          6'h2B: begin aluOp = ALU_SLTU; reg_wen = 1'b1; end
          6'h00: begin aluOp = ALU_SLL; aluA = rd2; reg_wen = 1'b1; end
          6'h02: begin aluOp = ALU_SRL; aluA = rd2; reg_wen = 1'b1; end
          6'h03: begin aluOp = ALU_SRA; aluA = rd2; reg_wen = 1'b1; end
          6'h08: isJr = 1'b1;
          6'h0C: begin ra1 = 5'd2; ra2 = 5'd4; is_syscall = 1'b1; end
          default: ;
        endcase
      end
      6'h08, 6'h09: begin wa = rt; reg_wen = 1'b1; aluB = immS; aluOp = ALU_ADD;  end
      6'h0A: begin wa = rt; reg_wen = 1'b1; aluB = immS; aluOp = ALU_SLT;  end
      6'h0B: begin wa = rt; reg_wen = 1'b1; aluB = immS; aluOp = ALU_SLTU; end
      6'h0C: begin wa = rt; reg_wen = 1'b1; aluB = immZ; aluOp = ALU_AND;  end
      6'h0D: begin wa = rt; reg_wen = 1'b1; aluB = immZ; aluOp = ALU_OR;   end
      6'h0E: begin wa = rt; reg_wen = 1'b1; aluB = immZ; aluOp = ALU_XOR;  end
      6'h0F: begin wa = rt; reg_wen = 1'b1; aluB = immZ; aluOp = ALU_LUI;  end
      6'h23: begin wa = rt; reg_wen = 1'b1; aluB = immS; mem_cmd = 2'b01; reg_src = 2'b01; end
      6'h2B: begin wa = rt; aluB = immS; mem_cmd = 2'b10; end
      6'h04: begin aluOp = ALU_SUB; isBeq = 1'b1; end
      6'h05: begin aluOp = ALU_SUB; isBne = 1'b1; end
      6'h02: isJ = 1'b1;
      6'h03: begin isJ = 1'b1; wa = 5'd31; reg_wen = 1'b1; reg_src = 2'b10; end
      6'h1C: begin
        if (funct == 6'h00) begin
          spi_ctrl = 2'b01;
        end else if (funct == 6'h01) begin
          spi_ctrl = 2'b10;
          reg_wen  = 1'b1;
          reg_src  = 2'b11;
        end
      end
      default: ;
    endcase
  end

  // Subtraction is A + ~B + 1 so carry_out reads as "no borrow".
  always_comb begin
    sum       = {1'b0, aluA} + {1'b0, aluB};
    alu_out   = sum[31:0];
    carry_out = 1'b0;
    case (aluOp)
      ALU_ADD:  begin alu_out = sum[31:0]; carry_out = sum[32]; end
      ALU_SUB:  begin
        sum       = {1'b0, aluA} + {1'b0, ~aluB} + 33'd1;
        alu_out   = sum[31:0];
        carry_out = sum[32];
      end
      ALU_AND:  alu_out = aluA & aluB;
      ALU_OR:   alu_out = aluA | aluB;
      ALU_XOR:  alu_out = aluA ^ aluB;
      ALU_NOR:  alu_out = ~(aluA | aluB);
      ALU_SLT:  alu_out = ($signed(aluA) < $signed(aluB)) ? 32'd1 : 32'd0;
      ALU_SLTU: alu_out = (aluA < aluB) ? 32'd1 : 32'd0;
      ALU_SLL:  alu_out = aluA << shamt;
      ALU_SRL:  alu_out = aluA >> shamt;
      ALU_SRA:  alu_out = $signed(aluA) >>> shamt;
      ALU_LUI:  alu_out = {aluB[15:0], 16'h0000};
      default:  alu_out = sum[31:0];
    endcase
  end

  assign is_zero = (alu_out == 32'd0);

  always_comb begin
    pc_d = pc_plus4;
    if (isJ) begin
      pc_d = {pc_plus4[31:28], inst[25:0], 2'b00};
    end else if (isJr) begin
      pc_d = rd1;
    end else if ((isBeq && is_zero) || (isBne && !is_zero)) begin
      pc_d = pc_plus4 + brOffset;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_cpu_fetch_decode_exec.sv
// Directed self-checking bench for cpu_fetch_decode_exec: hand-computed vectors
// for reset, ALU ops, decode controls and every next-PC source.
module tb_cpu_fetch_decode_exec;

  logic        clk;
  logic        rst;
  logic [31:0] inst, rd1, rd2;
  logic [31:0] pc, pc_plus4, alu_out;
  logic [4:0]  ra1, ra2, wa;
  logic        reg_wen, carry_out, is_zero, is_syscall;
  logic [1:0]  reg_src, mem_cmd, spi_ctrl;

  int totalCount;
  int failCount;
  int passCount;

  cpu_fetch_decode_exec #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .inst(inst), .rd1(rd1), .rd2(rd2),
    .pc(pc), .pc_plus4(pc_plus4), .ra1(ra1), .ra2(ra2), .wa(wa),
    .reg_wen(reg_wen), .reg_src(reg_src), .mem_cmd(mem_cmd), .spi_ctrl(spi_ctrl),
    .alu_out(alu_out), .carry_out(carry_out), .is_zero(is_zero), .is_syscall(is_syscall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Present one instruction with its operands and let combinational logic settle.
  task automatic applyStimulus(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    inst = i;
    rd1  = a;
    rd2  = b;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    totalCount = 0;
    failCount  = 0;
    rst  = 1'b1;
    inst = 32'h0;
    rd1  = 32'h0;
    rd2  = 32'h0;
    #1;
    checkOutput("reset_pc", pc, 32'h0000_0000);

    @(negedge clk);
    rst = 1'b0;
    stepClock();
    checkOutput("pc_after_release", pc, 32'h0000_0004);
    stepClock();
    checkOutput("pc_second_step", pc, 32'h0000_0008);

    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_pc", pc, 32'h0000_0000);
    stepClock();
    checkOutput("reset_held_pc", pc, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    stepClock();
    checkOutput("pc_after_rerelease", pc, 32'h0000_0004);

    applyStimulus(rType(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'h7FFF_FFFF, 32'h0000_0001);
    checkOutput("add_out", alu_out, 32'h8000_0000);
    checkOutput("add_carry", {31'b0, carry_out}, 32'd0);
    checkOutput("add_wa", {27'b0, wa}, 32'd3);
    checkOutput("add_wen", {31'b0, reg_wen}, 32'd1);

    applyStimulus(rType(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'hFFFF_FFFF, 32'h0000_0001);
    checkOutput("addu_out", alu_out, 32'h0000_0000);
    checkOutput("addu_carry", {31'b0, carry_out}, 32'd1);
    checkOutput("addu_zero", {31'b0, is_zero}, 32'd1);

    applyStimulus(rType(5'd1, 5'd2, 5'd3, 5'd0, 6'h23), 32'd5, 32'd3);
    checkOutput("subu_out", alu_out, 32'd2);
    checkOutput("subu_noborrow", {31'b0, carry_out}, 32'd1);
    applyStimulus(rType(5'd1, 5'd2, 5'd3, 5'd0, 6'h22), 32'd3, 32'd5);
    checkOutput("sub_out", alu_out, 32'hFFFF_FFFE);
    checkOutput("sub_borrow", {31'b0, carry_out}, 32'd0);

    applyStimulus(rType(5'd1, 5'd2, 5'd3, 5'd0, 6'h2A), 32'hFFFF_FFFF, 32'h0000_0001);
    checkOutput("slt_out", alu_out, 32'd1);
    applyStimulus(rType(5'd1, 5'd2, 5'd3, 5'd0, 6'h2B), 32'hFFFF_FFFF, 32'h0000_0001);
    checkOutput("sltu_out", alu_out, 32'd0);
    applyStimulus(rType(5'd0, 5'd2, 5'd3, 5'd4, 6'h03), 32'h0000_0000, 32'h8000_0000);
    checkOutput("sra_out", alu_out, 32'hF800_0000);
    applyStimulus(rType(5'd0, 5'd2, 5'd3, 5'd4, 6'h02), 32'h0000_0000, 32'h8000_0000);
    checkOutput("srl_out", alu_out, 32'h0800_0000);
    applyStimulus(rType(5'd1, 5'd2, 5'd3, 5'd0, 6'h27), 32'h0F0F_0000, 32'h0000_00F0);
    checkOutput("nor_out", alu_out, 32'hF0F0_FF0F);

    applyStimulus(iType(6'h0F, 5'd0, 5'd5, 16'h1234), 32'hDEAD_BEEF, 32'h0);
    checkOutput("lui_out", alu_out, 32'h1234_0000);
    checkOutput("lui_wa", {27'b0, wa}, 32'd5);
    applyStimulus(iType(6'h0C, 5'd1, 5'd5, 16'h8000), 32'hFFFF_FFFF, 32'h0);
    checkOutput("andi_zext", alu_out, 32'h0000_8000);
    applyStimulus(iType(6'h08, 5'd1, 5'd5, 16'hFFFF), 32'h0000_0000, 32'h0);
    checkOutput("addi_sext", alu_out, 32'hFFFF_FFFF);

    applyStimulus({6'h02, 26'h000_0040}, 32'h0, 32'h0);
    checkOutput("j_wen", {31'b0, reg_wen}, 32'd0);
    stepClock();
    checkOutput("j_pc", pc, 32'h0000_0100);
    applyStimulus(iType(6'h04, 5'd1, 5'd2, 16'hFFFE), 32'd5, 32'd5);
    checkOutput("beq_zero", {31'b0, is_zero}, 32'd1);
    checkOutput("beq_wen", {31'b0, reg_wen}, 32'd0);
    stepClock();
    checkOutput("beq_taken_pc", pc, 32'h0000_00FC);

    applyStimulus({6'h02, 26'h000_0040}, 32'h0, 32'h0);
    stepClock();
    applyStimulus(iType(6'h05, 5'd1, 5'd2, 16'hFFFE), 32'd5, 32'd5);
    stepClock();
    checkOutput("bne_not_taken_pc", pc, 32'h0000_0104);

    applyStimulus(rType(5'd1, 5'd0, 5'd0, 5'd0, 6'h08), 32'hF000_0010, 32'h0);
    checkOutput("jr_wen", {31'b0, reg_wen}, 32'd0);
    stepClock();
    checkOutput("jr_pc", pc, 32'hF000_0010);
    applyStimulus({6'h03, 26'h000_0010}, 32'h0, 32'h0);
    checkOutput("jal_wa", {27'b0, wa}, 32'd31);
    checkOutput("jal_src", {30'b0, reg_src}, 32'd2);
    checkOutput("jal_wen", {31'b0, reg_wen}, 32'd1);
    checkOutput("jal_link", pc_plus4, 32'hF000_0014);
    stepClock();
    checkOutput("jal_pc", pc, 32'hF000_0040);
    applyStimulus(rType(5'd1, 5'd0, 5'd0, 5'd0, 6'h08), 32'h0000_0200, 32'h0);
    stepClock();
    checkOutput("jr2_pc", pc, 32'h0000_0200);

    applyStimulus(iType(6'h2B, 5'd1, 5'd2, 16'hFFFC), 32'h0000_1000, 32'h1234_5678);
    checkOutput("sw_addr", alu_out, 32'h0000_0FFC);
    checkOutput("sw_cmd", {30'b0, mem_cmd}, 32'd2);
    checkOutput("sw_wen", {31'b0, reg_wen}, 32'd0);
    applyStimulus(iType(6'h23, 5'd1, 5'd6, 16'h0008), 32'h0000_1000, 32'h0);
    checkOutput("lw_addr", alu_out, 32'h0000_1008);
    checkOutput("lw_cmd", {30'b0, mem_cmd}, 32'd1);
    checkOutput("lw_src", {30'b0, reg_src}, 32'd1);
    checkOutput("lw_wa", {27'b0, wa}, 32'd6);

    applyStimulus(rType(5'd9, 5'd10, 5'd0, 5'd0, 6'h0C), 32'h0, 32'h0);
    checkOutput("sys_ra1", {27'b0, ra1}, 32'd2);
    checkOutput("sys_ra2", {27'b0, ra2}, 32'd4);
    checkOutput("sys_flag", {31'b0, is_syscall}, 32'd1);
    checkOutput("sys_wen", {31'b0, reg_wen}, 32'd0);

    applyStimulus({6'h1C, 5'd3, 5'd0, 5'd7, 5'd0, 6'h01}, 32'h0, 32'h0);
    checkOutput("mf_ctrl", {30'b0, spi_ctrl}, 32'd2);
    checkOutput("mf_wa", {27'b0, wa}, 32'd7);
    checkOutput("mf_src", {30'b0, reg_src}, 32'd3);
    checkOutput("mf_wen", {31'b0, reg_wen}, 32'd1);
    applyStimulus({6'h1C, 5'd3, 5'd4, 5'd0, 5'd0, 6'h00}, 32'h0, 32'h0);
    checkOutput("mt_ctrl", {30'b0, spi_ctrl}, 32'd1);
    checkOutput("mt_wen", {31'b0, reg_wen}, 32'd0);
    checkOutput("mt_ra1", {27'b0, ra1}, 32'd3);

    applyStimulus({6'h3F, 26'h3FF_FFFF}, 32'h0, 32'h0);
    checkOutput("undef_wen", {31'b0, reg_wen}, 32'd0);
    checkOutput("undef_mem", {30'b0, mem_cmd}, 32'd0);
    stepClock();
    checkOutput("undef_pc", pc, 32'h0000_0204);

    applyStimulus(rType(5'd1, 5'd0, 5'd0, 5'd0, 6'h08), 32'hFFFF_FFFC, 32'h0);
    stepClock();
    applyStimulus(32'h0000_0000, 32'h0, 32'h0);
    stepClock();
    checkOutput("pc_wrap", pc, 32'h0000_0000);

    passCount = totalCount - failCount;
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
